// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// control_pkg - opcodes, state encoding and step width for control_sequencer
// Rev 1.0
// ============================================================================
package control_pkg;

  localparam int STEP_W = 4;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  typedef enum logic [STEP_W-1:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_HALT = 4'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_BINARY  = 2'd0,
    CLS_UNARY   = 2'd1,
    CLS_HALT    = 2'd2,
    CLS_ILLEGAL = 2'd3
  } opc_class_t;

endpackage
`default_nettype wire

// File: rtl/onehot_decoder.sv
`default_nettype none
// ============================================================================
// onehot_decoder - binary index to one-hot enable vector, gated by en
// Rev 1.0
// ============================================================================
module onehot_decoder #(
  parameter int N = 16
) (
  input  logic [$clog2(N)-1:0] idx,
  input  logic                 en,
  output logic [N-1:0]         onehot
);

  localparam int IDX_W = $clog2(N);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign onehot[i] = en && (idx == IDX_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// control_sequencer - hardwired T0..T5 fetch/execute sequencer, single-bus path
// Optional feature macro: MEM_WAIT_EN (T1 stalls until mem_ready).  Rev 1.0
// ============================================================================
module control_sequencer
  import control_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [WIDTH-1:0]    ir,
  input  logic                mem_ready,
  output logic                pco,
  output logic                pc_inc,
  output logic                mari,
  output logic                read,
  output logic                mdri,
  output logic                mdro,
  output logic                iri,
  output logic                ryi,
  output logic                zi,
  output logic                zo,
  output logic [NUM_REGS-1:0] rf_out,
  output logic [NUM_REGS-1:0] rf_in,
  output logic [OPC_W-1:0]    alu_op,
  output logic [STEP_W-1:0]   step,
  output logic                halted,
  output logic                illegal
);

  localparam int IDX_W = $clog2(NUM_REGS);

  localparam logic [OPC_W-1:0] c_add  = OPC_W'(OPC_ADD);
  localparam logic [OPC_W-1:0] c_sub  = OPC_W'(OPC_SUB);
  localparam logic [OPC_W-1:0] c_and  = OPC_W'(OPC_AND);
  localparam logic [OPC_W-1:0] c_or   = OPC_W'(OPC_OR);
  localparam logic [OPC_W-1:0] c_neg  = OPC_W'(OPC_NEG);
  localparam logic [OPC_W-1:0] c_not  = OPC_W'(OPC_NOT);
  localparam logic [OPC_W-1:0] c_halt = OPC_W'(OPC_HALT);

  function automatic opc_class_t classify(input logic [OPC_W-1:0] opc);
    opc_class_t cls;
    if (opc == c_add || opc == c_sub || opc == c_and || opc == c_or)
      cls = CLS_BINARY;
    else if (opc == c_neg || opc == c_not)
      cls = CLS_UNARY;
    else if (opc == c_halt)
      cls = CLS_HALT;
    else
      cls = CLS_ILLEGAL;
    return cls;
  endfunction

  state_t             r_state;
  logic [OPC_W-1:0]   r_opc;
  logic [IDX_W-1:0]   r_ra;
  logic [IDX_W-1:0]   r_rb;
  logic [IDX_W-1:0]   r_rc;

  logic [OPC_W-1:0]   w_ir_opc;
  logic [IDX_W-1:0]   w_ir_ra;
  logic [IDX_W-1:0]   w_ir_rb;
  logic [IDX_W-1:0]   w_ir_rc;
  opc_class_t         w_cls;
  logic               w_out_en;
  logic [IDX_W-1:0]   w_out_idx;
  logic               w_in_en;
  logic               w_unused;

  assign w_ir_opc = ir[WIDTH-1 -: OPC_W];
  assign w_ir_ra  = ir[WIDTH-1-OPC_W -: IDX_W];
  assign w_ir_rb  = ir[WIDTH-1-OPC_W-IDX_W -: IDX_W];
  assign w_ir_rc  = ir[WIDTH-1-OPC_W-2*IDX_W -: IDX_W];
  assign w_cls    = classify(w_ir_opc);

  // IR is loaded at the end of T2, so T3 decodes the live ir and captures it
  // on the way out; T4/T5 then depend only on the captured copy.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= ST_IDLE;
      r_opc   <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (run) r_state <= ST_T0;
        ST_T0:   r_state <= ST_T1;
        ST_T1: begin
`ifdef MEM_WAIT_EN
          if (mem_ready) r_state <= ST_T2;
`else
          r_state <= ST_T2;
`endif
        end
        ST_T2:   r_state <= ST_T3;
        ST_T3: begin
          r_opc <= w_ir_opc;
          r_ra  <= w_ir_ra;
          r_rb  <= w_ir_rb;
          r_rc  <= w_ir_rc;
          case (w_cls)
            CLS_BINARY: r_state <= ST_T4;
            CLS_UNARY:  r_state <= ST_T5;
            CLS_HALT:   r_state <= ST_HALT;
            default:    r_state <= ST_T0;
          endcase
        end
        ST_T4:   r_state <= ST_T5;
        ST_T5:   r_state <= run ? ST_T0 : ST_IDLE;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pco       = 1'b0;
    pc_inc    = 1'b0;
    mari      = 1'b0;
    read      = 1'b0;
    mdri      = 1'b0;
    mdro      = 1'b0;
    iri       = 1'b0;
    ryi       = 1'b0;
    zi        = 1'b0;
    zo        = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    alu_op    = '0;
    w_out_en  = 1'b0;
    w_out_idx = r_rc;
    w_in_en   = 1'b0;
    case (r_state)
      ST_T0: begin
        pco    = 1'b1;
        pc_inc = 1'b1;
        mari   = 1'b1;
      end
      ST_T1: begin
        read = 1'b1;
`ifdef MEM_WAIT_EN
        mdri = mem_ready;
`else
        mdri = 1'b1;
`endif
      end
      ST_T2: begin
        mdro = 1'b1;
        iri  = 1'b1;
      end
      ST_T3: begin
        case (w_cls)
          CLS_BINARY: begin
            w_out_en  = 1'b1;
            w_out_idx = w_ir_rb;
            ryi       = 1'b1;
          end
          CLS_UNARY: begin
            w_out_en  = 1'b1;
            w_out_idx = w_ir_rb;
            alu_op    = w_ir_opc;
            zi        = 1'b1;
          end
          CLS_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        w_out_en  = 1'b1;
        w_out_idx = r_rc;
        alu_op    = r_opc;
        zi        = 1'b1;
      end
      ST_T5: begin
        zo      = 1'b1;
        w_in_en = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign step = r_state;

  onehot_decoder #(.N(NUM_REGS)) u_rf_out_dec (
    .idx    (w_out_idx),
    .en     (w_out_en),
    .onehot (rf_out)
  );

  onehot_decoder #(.N(NUM_REGS)) u_rf_in_dec (
    .idx    (r_ra),
    .en     (w_in_en),
    .onehot (rf_in)
  );

  // Low ir bits and the latched rb carry no control meaning after T3.
`ifdef MEM_WAIT_EN
  assign w_unused = ^{ir, r_rb};
`else
  assign w_unused = ^{ir, r_rb, mem_ready};
`endif

endmodule
`default_nettype wire
